// File: rtl/seg7_pkg.sv
// Character codes, active-low segment patterns and the pattern->code lookup
// shared by the HEX read-back path.
package seg7_pkg;

    typedef enum logic [2:0] {
        CH_H     = 3'b000,
        CH_E     = 3'b001,
        CH_L     = 3'b010,
        CH_O     = 3'b011,
        CH_BLANK = 3'b100,
        CH_ERR   = 3'b111
    } char_t;

    // Active-low patterns, bit6=g .. bit0=a
    localparam logic [6:0] PAT_H     = 7'b0001001;
    localparam logic [6:0] PAT_E     = 7'b0000110;
    localparam logic [6:0] PAT_L     = 7'b1000111;
    localparam logic [6:0] PAT_O     = 7'b1000000;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    function automatic char_t decode_pat(input logic [6:0] pat);
        char_t code;
        case (pat)
            PAT_H:     code = CH_H;
            PAT_E:     code = CH_E;
            PAT_L:     code = CH_L;
            PAT_O:     code = CH_O;
            PAT_BLANK: code = CH_BLANK;
            default:   code = CH_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_char_reader_if.sv
// Character output handshake plus the sticky overrun flag and its clear.
interface seg7_char_reader_if;
    import seg7_pkg::*;

    char_t out_code;
    logic  out_err;
    logic  out_valid;
    logic  out_ready;
    logic  overrun;
    logic  overrun_clr;

    modport master (
        output out_code, out_err, out_valid, overrun,
        input  out_ready, overrun_clr
    );

    modport slave (
        input  out_code, out_err, out_valid, overrun,
        output out_ready, overrun_clr
    );

endinterface

// File: rtl/seg7_bus_sync.sv
// Synchronises the asynchronous segment bus and strobes accept once per new
// pattern that has been stable for STABLE_CYCLES samples.
module seg7_bus_sync
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [6:0] pat,
    output logic       accept
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       s1, s2, prev, last_pat;
    logic [CNT_W-1:0] cnt;

    // Blank reset values mean an idle bus after reset never produces output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= PAT_BLANK;
            s2       <= PAT_BLANK;
            prev     <= PAT_BLANK;
            last_pat <= PAT_BLANK;
            cnt      <= '0;
        end else begin
            s1   <= seg_in;
            s2   <= s1;
            prev <= s2;
            if (s2 != prev)
                cnt <= '0;
            else if (cnt < CNT_MAX)
                cnt <= cnt + 1'b1;
            if (accept)
                last_pat <= s2;
        end
    end

    // Saturated counter plus last_pat compare gives exactly one strobe per change.
    assign accept = (cnt == CNT_MAX) && (s2 == prev) && (s2 != last_pat);
    assign pat    = s2;

endmodule

// File: rtl/seg7_char_reader.sv
// Reads an active-low 7-segment bus back into a character code and delivers
// each new stable character once over valid/ready, flagging drops as overrun.
module seg7_char_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    input  logic [6:0]          seg_in,
    seg7_char_reader_if.master  bus
);

    logic [6:0] pat;
    logic       accept;
    char_t      dec;
    logic       load, drop;

    char_t      code_q;
    logic       err_q, valid_q, ovr_q;

    seg7_bus_sync #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_sync (
        .clk    (CLOCK_50),
        .rst_n  (KEY0),
        .seg_in (seg_in),
        .pat    (pat),
        .accept (accept)
    );

    assign dec  = decode_pat(pat);
    // A slot frees up in the same cycle the consumer takes the held character.
    assign load = accept && (!valid_q || bus.out_ready);
    assign drop = accept && valid_q && !bus.out_ready;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            code_q  <= CH_H;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) begin
                code_q  <= dec;
                err_q   <= (dec == CH_ERR);
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            // Set has priority over a coincident clear.
            if (drop)
                ovr_q <= 1'b1;
            else if (bus.overrun_clr)
                ovr_q <= 1'b0;
        end
    end

    assign bus.out_code  = code_q;
    assign bus.out_err   = err_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_char_reader.sv
// Vector table plus scoreboard for seg7_char_reader; hand sequences cover
// latency, overrun, set-vs-clear priority and mid-stream reset.
module tb_seg7_char_reader;
    import seg7_pkg::*;

    localparam int STABLE = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg   = 7'h7F;

    seg7_char_reader_if intf();

    seg7_char_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .CLOCK_50 (clk),
        .KEY0     (rst_n),
        .seg_in   (seg),
        .bus      (intf.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic       err;
    } exp_t;

    typedef struct {
        logic [6:0] pat;
        int         hold;
        bit         emit;
        logic [2:0] code;
        logic       err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] code, input logic err);
        exp_t e;
        e.code = code;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (intf.out_valid === 1'b1) break;
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && intf.out_valid === 1'b1 && intf.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got code %0h err %0b want nothing",
                         intf.out_code, intf.out_err);
            end else begin
                e = sb.pop_front();
                chk("out_code", 32'(intf.out_code), 32'(e.code));
                chk("out_err", 32'(intf.out_err), 32'(e.err));
            end
        end
    end

    initial begin
        int n;

        vecs[0]  = '{7'b1111111, 20, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{7'b0001001, 10, 1'b1, 3'b000, 1'b0};
        vecs[2]  = '{7'b1111111, 10, 1'b1, 3'b100, 1'b0};
        vecs[3]  = '{7'b1000000,  3, 1'b0, 3'b000, 1'b0};
        vecs[4]  = '{7'b1111111, 10, 1'b0, 3'b000, 1'b0};
        vecs[5]  = '{7'b1000000, 10, 1'b1, 3'b011, 1'b0};
        vecs[6]  = '{7'b0101010, 10, 1'b1, 3'b111, 1'b1};
        vecs[7]  = '{7'b0000110, 10, 1'b1, 3'b001, 1'b0};
        vecs[8]  = '{7'b1000111, 10, 1'b1, 3'b010, 1'b0};
        vecs[9]  = '{7'b0000110,  2, 1'b0, 3'b000, 1'b0};
        vecs[10] = '{7'b1000111, 10, 1'b0, 3'b000, 1'b0};

        intf.out_ready   = 1'b1;
        intf.overrun_clr = 1'b0;
        cycles(3);
        chk("rst_valid", 32'(intf.out_valid), 0);
        chk("rst_code", 32'(intf.out_code), 0);
        chk("rst_err", 32'(intf.out_err), 0);
        chk("rst_overrun", 32'(intf.overrun), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            seg = vecs[i].pat;
            if (vecs[i].emit) push(vecs[i].code, vecs[i].err);
            cycles(vecs[i].hold);
        end
        chk("table_drained", 32'(sb.size()), 0);
        chk("idle_overrun", 32'(intf.overrun), 0);

        // Latency from drive to out_valid, then a single-cycle pulse
        seg = 7'b0001001;
        push(3'b000, 1'b0);
        wait_valid(n);
        chk("latency", 32'(n), 32'(STABLE + 3));
        cycles(1);
        chk("pulse_one_cycle", 32'(intf.out_valid), 0);
        cycles(8);

        // Held character with a dropped follower
        intf.out_ready = 1'b0;
        seg = 7'b1000000;
        push(3'b011, 1'b0);
        cycles(10);
        chk("held_valid", 32'(intf.out_valid), 1);
        chk("held_code", 32'(intf.out_code), 3);
        seg = 7'b0000110;
        cycles(10);
        chk("ovr_set", 32'(intf.overrun), 1);
        chk("ovr_code_kept", 32'(intf.out_code), 3);
        chk("ovr_valid_kept", 32'(intf.out_valid), 1);
        intf.out_ready = 1'b1;
        cycles(1);
        intf.out_ready = 1'b0;
        chk("valid_after_hs", 32'(intf.out_valid), 0);
        chk("ovr_sticky", 32'(intf.overrun), 1);
        intf.overrun_clr = 1'b1;
        cycles(1);
        intf.overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(intf.overrun), 0);

        // Clear coinciding with a new drop: set must win
        seg = 7'b1000111;
        push(3'b010, 1'b0);
        cycles(10);
        seg = 7'b0001001;
        cycles(STABLE + 2);
        chk("ovr_pre_drop", 32'(intf.overrun), 0);
        intf.overrun_clr = 1'b1;
        cycles(1);
        intf.overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(intf.overrun), 1);
        chk("set_wins_code", 32'(intf.out_code), 2);
        intf.out_ready = 1'b1;
        cycles(2);
        intf.overrun_clr = 1'b1;
        cycles(1);
        intf.overrun_clr = 1'b0;

        // Asynchronous reset while a character is held
        intf.out_ready = 1'b0;
        seg = 7'b0000110;
        push(3'b001, 1'b0);
        cycles(10);
        chk("pre_rst_valid", 32'(intf.out_valid), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(intf.out_valid), 0);
        chk("async_rst_code", 32'(intf.out_code), 0);
        chk("async_rst_err", 32'(intf.out_err), 0);
        sb.delete();
        seg = 7'b1000111;
        cycles(2);
        rst_n = 1'b1;
        push(3'b010, 1'b0);
        wait_valid(n);
        chk("latency_after_rst", 32'(n), 32'(STABLE + 3));
        chk("code_after_rst", 32'(intf.out_code), 2);
        intf.out_ready = 1'b1;
        cycles(4);
        chk("final_drained", 32'(sb.size()), 0);
        chk("final_overrun", 32'(intf.overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
